// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
// MDU_MADD_EN adds the madd/maddu/msub/msubu codes.
package mdu_pkg;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

`ifdef MDU_MADD_EN
  // Only meaningful with Start high, so they reuse codes that never assert Start.
  typedef enum logic [2:0] {
    MD_MADD  = 3'd5,
    MD_MADDU = 3'd6,
    MD_MSUB  = 3'd7,
    MD_MSUBU = 3'd0
  } md_mac_e;
`endif

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit signed/unsigned divider; quotient truncates toward zero,
// remainder takes the dividend's sign. Divide-by-zero and INT_MIN/-1 are flagged.
module mdu_divider (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o,
  output logic        div_zero_o,
  output logic        overflow_o
);

  logic [31:0]        b_safe;
  logic signed [31:0] s_quo;
  logic signed [31:0] s_rem;

  assign div_zero_o = (b_i == '0);
  assign overflow_o = signed_i && (a_i == 32'h8000_0000) && (b_i == '1);

  // A divisor of 1 in the flagged cases keeps the arithmetic defined.
  assign b_safe = (div_zero_o || overflow_o) ? 32'd1 : b_i;

  assign s_quo = $signed(a_i) / $signed(b_safe);
  assign s_rem = $signed(a_i) % $signed(b_safe);

  assign quo_o = signed_i ? s_quo : (a_i / b_safe);
  assign rem_o = signed_i ? s_rem : (a_i % b_safe);

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit holding architectural HI/LO.
// Define MDU_MADD_EN to add the madd/maddu/msub/msubu accumulate ops.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  input  logic        IntReq,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             start_ok;
  logic [31:0]      res_hi, res_lo;
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      quo, rem;
  logic             div_zero, div_ovf;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_q, lo_q};
`endif

  mdu_divider u_div (
    .a_i        (A),
    .b_i        (B),
    .signed_i   (MDOp == MD_DIV),
    .quo_o      (quo),
    .rem_o      (rem),
    .div_zero_o (div_zero),
    .overflow_o (div_ovf)
  );

  // Decode of Start-qualified ops: latency and the result to park in pend_*.
  always_comb begin
    start_ok = 1'b0;
    lat      = '0;
    res_hi   = hi_q;
    res_lo   = lo_q;
    case (MDOp)
      MD_MULT: begin
        start_ok         = 1'b1;
        lat              = CNT_W'(MULT_CYCLES);
        {res_hi, res_lo} = prod_s;
      end
      MD_MULTU: begin
        start_ok         = 1'b1;
        lat              = CNT_W'(MULT_CYCLES);
        {res_hi, res_lo} = prod_u;
      end
      MD_DIV, MD_DIVU: begin
        start_ok = 1'b1;
        lat      = CNT_W'(DIV_CYCLES);
        if (div_ovf) begin
          {res_hi, res_lo} = {32'h0, 32'h8000_0000};
        end else if (!div_zero) begin
          {res_hi, res_lo} = {rem, quo};
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        start_ok         = 1'b1;
        lat              = CNT_W'(MULT_CYCLES);
        {res_hi, res_lo} = acc + prod_s;
      end
      MD_MADDU: begin
        start_ok         = 1'b1;
        lat              = CNT_W'(MULT_CYCLES);
        {res_hi, res_lo} = acc + prod_u;
      end
      MD_MSUB: begin
        start_ok         = 1'b1;
        lat              = CNT_W'(MULT_CYCLES);
        {res_hi, res_lo} = acc - prod_s;
      end
      MD_MSUBU: begin
        start_ok         = 1'b1;
        lat              = CNT_W'(MULT_CYCLES);
        {res_hi, res_lo} = acc - prod_u;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (!IntReq) begin
          if (Start) begin
            if (start_ok) begin
              state_d   = ST_RUN;
              cnt_d     = lat;
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
            end
          end else if (MDOp == MD_MTHI) begin
            hi_d = A;
          end else if (MDOp == MD_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // Hazard logic must keep new MDU ops out of E while a run is in flight.
  a_no_issue_while_run: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_RUN) |-> !(Start || (MDOp == MD_MTHI) || (MDOp == MD_MTLO)));

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDOp;
  logic        Start, IntReq;
  logic        Busy;
  logic [31:0] HI, LO;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .MDOp   (MDOp),
    .Start  (Start),
    .IntReq (IntReq),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one E-stage issue, from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic st, input logic irq,
                       input logic [31:0] a, input logic [31:0] b,
                       output int unsigned lat);
    longint      sa, sb, q, r;
    logic [63:0] p, acc;
    lat = 0;
    if (irq) return;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {m_hi, m_lo};
    if (st) begin
      case (op)
        MD_MULT:  begin lat = MC; p = sa * sb; {m_hi, m_lo} = p; end
        MD_MULTU: begin lat = MC; p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
        MD_DIV: begin
          lat = DC;
          if (b != 0) begin
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
          end
        end
        MD_DIVU: begin
          lat = DC;
          if (b != 0) begin
            m_lo = a / b;
            m_hi = a % b;
          end
        end
`ifdef MDU_MADD_EN
        MD_MADD:  begin lat = MC; p = sa * sb; {m_hi, m_lo} = acc + p; end
        MD_MADDU: begin lat = MC; p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = acc + p; end
        MD_MSUB:  begin lat = MC; p = sa * sb; {m_hi, m_lo} = acc - p; end
        MD_MSUBU: begin lat = MC; p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = acc - p; end
`endif
        default: ;
      endcase
    end else if (op == MD_MTHI) begin
      m_hi = a;
    end else if (op == MD_MTLO) begin
      m_lo = a;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic st,
                        input logic irq, input logic [31:0] a, input logic [31:0] b);
    int unsigned lat, n;
    model(op, st, irq, a, b, lat);
    A = a; B = b; MDOp = op; Start = st; IntReq = irq;
    tick;
    Start = 1'b0; MDOp = MD_NOP; IntReq = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      IntReq = 1'($urandom_range(0, 1));
      A = $urandom; B = $urandom;
      n++;
      tick;
    end
    IntReq = 1'b0;
    check({tag, " busy"}, 64'(n), 64'(lat));
    check({tag, " hi"}, {32'b0, HI}, {32'b0, m_hi});
    check({tag, " lo"}, {32'b0, LO}, {32'b0, m_lo});
  endtask

  initial begin
    logic        st, irq;
    logic [2:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; A = '0; B = '0; MDOp = MD_NOP; Start = 1'b0; IntReq = 1'b0;
    tick;
    tick;
    check("reset busy", 64'(Busy), 64'd0);
    check("reset hi", {32'b0, HI}, 64'd0);
    check("reset lo", {32'b0, LO}, 64'd0);
    reset = 1'b0;
    tick;

    run_op("mult", MD_MULT, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2);
    check("mult hi const", {32'b0, HI}, 64'hFFFF_FFFF);
    check("mult lo const", {32'b0, LO}, 64'hFFFF_FFFE);
    run_op("multu", MD_MULTU, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2);
    check("multu hi const", {32'b0, HI}, 64'h1);
    check("multu lo const", {32'b0, LO}, 64'hFFFF_FFFE);
    run_op("div", MD_DIV, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    check("div hi const", {32'b0, HI}, 64'hFFFF_FFFF);
    check("div lo const", {32'b0, LO}, 64'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 1'b1, 1'b0, 32'd7, 32'd2);
    check("divu hi const", {32'b0, HI}, 64'h1);
    check("divu lo const", {32'b0, LO}, 64'h3);
    run_op("div ovf", MD_DIV, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div ovf hi const", {32'b0, HI}, 64'h0);
    check("div ovf lo const", {32'b0, LO}, 64'h8000_0000);

    run_op("mthi", MD_MTHI, 1'b0, 1'b0, 32'h1234, 32'd0);
    run_op("mtlo", MD_MTLO, 1'b0, 1'b0, 32'h5678, 32'd0);
    run_op("div0", MD_DIV, 1'b1, 1'b0, 32'd99, 32'd0);
    check("div0 hi const", {32'b0, HI}, 64'h1234);
    check("div0 lo const", {32'b0, LO}, 64'h5678);

    run_op("mult irq", MD_MULT, 1'b1, 1'b1, 32'd3, 32'd4);
    run_op("mtlo irq", MD_MTLO, 1'b0, 1'b1, 32'hDEAD, 32'd0);
    check("mtlo irq lo const", {32'b0, LO}, 64'h5678);
    run_op("code7", 3'd7, 1'b1, 1'b0, 32'd5, 32'd6);

`ifdef MDU_MADD_EN
    run_op("pre hi", MD_MTHI, 1'b0, 1'b0, 32'h0, 32'd0);
    run_op("pre lo", MD_MTLO, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd0);
    run_op("maddu", MD_MADDU, 1'b1, 1'b0, 32'd1, 32'd1);
    check("maddu hi const", {32'b0, HI}, 64'h1);
    check("maddu lo const", {32'b0, LO}, 64'h0);
`endif

    // Reset between clock edges three cycles into a divide.
    run_op("pre rst", MD_MTHI, 1'b0, 1'b0, 32'hAAAA, 32'd0);
    A = 32'd100; B = 32'd7; MDOp = MD_DIV; Start = 1'b1;
    tick;
    Start = 1'b0; MDOp = MD_NOP;
    tick;
    tick;
    tick;
    check("rst pre busy", 64'(Busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst busy", 64'(Busy), 64'd0);
    check("rst hi", {32'b0, HI}, 64'd0);
    check("rst lo", {32'b0, LO}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    tick;
    reset = 1'b0;
    tick;
    run_op("post rst mult", MD_MULT, 1'b1, 1'b0, 32'd6, 32'hFFFF_FFF9);

    for (int i = 0; i < 60; i++) begin
      st  = ($urandom_range(0, 3) != 0);
      op  = 3'($urandom_range(0, 7));
      irq = ($urandom_range(0, 7) == 0);
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      run_op("rand", op, st, irq, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
